// File: rtl/paralelo_serial_if.sv
// Parallel word in / 2-bit serial symbol out for the PHY transmit serialiser.
// The mux stage drives the master side and the serialiser is the slave.
interface paralelo_serial_if;
  logic [8:0] inParalelo;
  logic       in_ready;
  logic [1:0] serial;
  logic       tx_active;
  logic       err_bc;

  modport master (output inParalelo, input in_ready, serial, tx_active, err_bc);
  modport slave  (input inParalelo, output in_ready, serial, tx_active, err_bc);
endinterface

// File: rtl/paralelo_serial.sv
// Serialises {valid, data[7:0]} words into four 2-bit symbols, MSB pair first.
// A comma preamble follows reset, and commas fill every frame that carries no valid word.
module paralelo_serial #(
  parameter logic [7:0] COMMA       = 8'hBC,
  parameter int         PREAMBLE_BC = 4
) (
  input logic             clk16,
  input logic             reset16,
  paralelo_serial_if.slave bus
);
  localparam logic [3:0] PB_LAST = 4'(PREAMBLE_BC - 1);
  localparam logic [3:0] PB_SAT  = 4'(PREAMBLE_BC);

  logic [1:0] phase_q, phase_d;
  logic [7:0] byte_q, byte_d;
  logic [3:0] cnt_q, cnt_d;
  logic       tx_active_q, tx_active_d;
  logic       err_bc_q, err_bc_d;
  logic [1:0] serial_q, serial_d;
  logic       in_ready;

  function automatic logic [1:0] pick(input logic [7:0] b, input logic [1:0] p);
    case (p)
      2'd0:    pick = b[7:6];
      2'd1:    pick = b[5:4];
      2'd2:    pick = b[3:2];
      default: pick = b[1:0];
    endcase
  endfunction

  assign in_ready = tx_active_q && (phase_q == 2'd3);

  always_comb begin
    phase_d     = phase_q + 2'd1;
    byte_d      = byte_q;
    cnt_d       = cnt_q;
    tx_active_d = tx_active_q;
    err_bc_d    = 1'b0;
    // raise one cycle early so in_ready already covers the last preamble phase
    if (phase_q == 2'd2 && cnt_q == PB_LAST) tx_active_d = 1'b1;
    if (phase_q == 2'd3) begin
      if (cnt_q != PB_SAT) cnt_d = cnt_q + 4'd1;
      byte_d = COMMA;
      if (in_ready && bus.inParalelo[8]) begin
        byte_d   = bus.inParalelo[7:0];
        err_bc_d = (bus.inParalelo[7:0] == COMMA);
      end
    end
    serial_d = pick(byte_d, phase_d);
  end

  always_ff @(posedge clk16) begin
    if (reset16) begin
      phase_q     <= 2'd0;
      byte_q      <= COMMA;
      cnt_q       <= 4'd0;
      tx_active_q <= 1'b0;
      err_bc_q    <= 1'b0;
      serial_q    <= COMMA[7:6];
    end else begin
      phase_q     <= phase_d;
      byte_q      <= byte_d;
      cnt_q       <= cnt_d;
      tx_active_q <= tx_active_d;
      err_bc_q    <= err_bc_d;
      serial_q    <= serial_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.serial    = serial_q;
  assign bus.tx_active = tx_active_q;
  assign bus.err_bc    = err_bc_q;
endmodule

// File: tb/tb_paralelo_serial.sv
// Self-checking bench for paralelo_serial: directed sequences, a vector table and a random run.
module tb_paralelo_serial;
  localparam logic [7:0] COMMA = 8'hBC;
  localparam int         PB    = 4;

  logic clk16 = 1'b0;
  logic reset16 = 1'b1;
  always #5 clk16 = ~clk16;

  paralelo_serial_if bus();
  paralelo_serial #(.COMMA(COMMA), .PREAMBLE_BC(PB)) dut (
    .clk16(clk16), .reset16(reset16), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [8:0] word;
    logic [7:0] exp_byte;
    logic       exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk16); #1;
  endtask

  // after this returns the bench sits in cycle 0 after reset release
  task automatic do_reset();
    reset16 = 1'b1;
    step();
    reset16 = 1'b0;
  endtask

  function automatic logic [1:0] sym(input logic [7:0] b, input int p);
    logic [7:0] s;
    s = b >> (6 - 2 * p);
    return s[1:0];
  endfunction

  task automatic wait_ready();
    int k;
    for (k = 0; k < 8 && bus.in_ready !== 1'b1; k++) step();
    if (bus.in_ready !== 1'b1) chk("wait_in_ready_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  vec_t vecs[7];
  logic [7:0] fbyte[$];
  logic [7:0] acc[$];

  initial begin
    logic [7:0] rx;
    logic       pend_err;
    logic [8:0] w;

    vecs[0] = '{9'h0A5, 8'hBC, 1'b0};
    vecs[1] = '{9'h1BC, 8'hBC, 1'b1};
    vecs[2] = '{9'h100, 8'h00, 1'b0};
    vecs[3] = '{9'h1FF, 8'hFF, 1'b0};
    vecs[4] = '{9'h13C, 8'h3C, 1'b0};
    vecs[5] = '{9'h0BC, 8'hBC, 1'b0};
    vecs[6] = '{9'h1A5, 8'hA5, 1'b0};

    bus.inParalelo = 9'h1A5;
    do_reset();
    chk("rst_serial", 32'(bus.serial), 32'd2);
    chk("rst_tx_active", 32'(bus.tx_active), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_err_bc", 32'(bus.err_bc), 32'd0);

    // preamble with a valid word held throughout
    for (int t = 0; t < 20; t++) begin
      chk($sformatf("pre_serial_t%0d", t), 32'(bus.serial),
          32'(sym((t < 16) ? COMMA : 8'hA5, t % 4)));
      chk($sformatf("pre_tx_active_t%0d", t), 32'(bus.tx_active), 32'(t >= 15));
      chk($sformatf("pre_in_ready_t%0d", t), 32'(bus.in_ready), 32'(t == 15 || t == 19));
      step();
    end

    // back-to-back table, with junk offered outside in_ready
    wait_ready();
    for (int i = 0; i < 7; i++) begin
      bus.inParalelo = vecs[i].word;
      step();
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("vec%0d_serial_p%0d", i, p), 32'(bus.serial), 32'(sym(vecs[i].exp_byte, p)));
        chk($sformatf("vec%0d_err_p%0d", i, p), 32'(bus.err_bc), 32'((p == 0) ? vecs[i].exp_err : 1'b0));
        chk($sformatf("vec%0d_in_ready_p%0d", i, p), 32'(bus.in_ready), 32'(p == 3));
        if (p == 1) bus.inParalelo = 9'h1BC;
        if (p == 2) bus.inParalelo = 9'h100 | 9'($urandom_range(0, 255));
        if (p < 3) step();
      end
    end

    // reset at phase 2 of a data frame
    bus.inParalelo = 9'h1FF;
    step(); step(); step();
    chk("mid_phase2_serial", 32'(bus.serial), 32'(sym(8'hFF, 2)));
    reset16 = 1'b1;
    bus.inParalelo = 9'h0A5;
    step();
    reset16 = 1'b0;
    for (int t = 0; t < 16; t++) begin
      chk($sformatf("rerst_serial_t%0d", t), 32'(bus.serial), 32'(sym(COMMA, t % 4)));
      chk($sformatf("rerst_tx_active_t%0d", t), 32'(bus.tx_active), 32'(t == 15));
      chk($sformatf("rerst_in_ready_t%0d", t), 32'(bus.in_ready), 32'(t == 15));
      step();
    end

    // random traffic against a frame-indexed model plus a receive-side scoreboard
    do_reset();
    fbyte.delete();
    acc.delete();
    fbyte.push_back(COMMA);
    pend_err = 1'b0;
    rx = 8'h00;
    for (int t = 0; t < 4000; t++) begin
      int p, f;
      logic exp_ir;
      p = t % 4;
      f = t / 4;
      exp_ir = (t >= 4 * PB - 1) && (p == 3);
      chk("rnd_serial", 32'(bus.serial), 32'(sym(fbyte[f], p)));
      chk("rnd_flags", 32'({bus.tx_active, bus.in_ready, bus.err_bc}),
          32'({(t >= 4 * PB - 1), exp_ir, pend_err}));
      rx = {rx[5:0], bus.serial};
      if (p == 3 && f >= PB && rx != COMMA) begin
        if (acc.size() == 0) chk("rx_unexpected_word", 32'(rx), 32'(COMMA));
        else chk("rx_word", 32'(rx), 32'(acc.pop_front()));
      end
      w[8]   = ($urandom_range(0, 3) != 0);
      w[7:0] = ($urandom_range(0, 7) == 0) ? COMMA : 8'($urandom);
      bus.inParalelo = w;
      pend_err = 1'b0;
      if (p == 3) begin
        if (exp_ir && w[8]) begin
          fbyte.push_back(w[7:0]);
          pend_err = (w[7:0] == COMMA);
          if (w[7:0] != COMMA) acc.push_back(w[7:0]);
        end else begin
          fbyte.push_back(COMMA);
        end
      end
      step();
    end
    chk("rx_backlog", 32'(acc.size() <= 1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
